// File: rtl/dual_port_ram_sc.sv
// dual_port_ram_sc: single-clock simple dual-port RAM
// one write port, one registered read port, read-first
module dual_port_ram_sc #(
  parameter int addr_width = 8,
  parameter int dta_width  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [addr_width-1:0] wr_addr,
  input  logic [dta_width-1:0]  din,
  input  logic                  rd_en,
  input  logic [addr_width-1:0] rd_addr,
  output logic [dta_width-1:0]  dout
);

  localparam int depth = 1 << addr_width;

  logic [dta_width-1:0] mem [depth];

  // write port; not gated by rst so init writes may overlap reset
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_addr] <= din;
  end

  // registered read port; sees pre-write contents (read-first)
  always_ff @(posedge clk) begin
    if (rst)
      dout <= '0;
    else if (rd_en)
      dout <= mem[rd_addr];
  end

endmodule

// File: tb/tb_dual_port_ram_sc.sv
// tb_dual_port_ram_sc: vector table, corner sequences
// and randomized traffic against a behavioural model
module tb_dual_port_ram_sc;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [5:0] wr_addr = '0;
  logic [7:0] din = '0;
  logic       rd_en = 1'b0;
  logic [5:0] rd_addr = '0;
  logic [7:0] dout;

  dual_port_ram_sc #(
    .addr_width(6),
    .dta_width (8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .din    (din),
    .rd_en  (rd_en),
    .rd_addr(rd_addr),
    .dout   (dout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       we;
    logic [5:0] wa;
    logic [7:0] d;
    logic       re;
    logic [5:0] ra;
    logic       chk;
    logic [7:0] exp;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mem_m [64];
  logic [7:0] dout_m;

  function automatic vec_t mk(
    input logic r, input logic we,
    input logic [5:0] wa, input logic [7:0] d,
    input logic re, input logic [5:0] ra,
    input logic chk, input logic [7:0] exp
  );
    vec_t v;
    v.rst = r; v.we = we; v.wa = wa; v.d = d;
    v.re = re; v.ra = ra; v.chk = chk; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string nm,
                       input logic [7:0] act,
                       input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: dout=%h expected=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // one clock of stimulus; model advances from the same inputs
  task automatic run(input vec_t v, input string nm);
    @(negedge clk);
    rst = v.rst; wr_en = v.we; wr_addr = v.wa;
    din = v.d; rd_en = v.re; rd_addr = v.ra;
    @(posedge clk);
    #1;
    if (v.rst) dout_m = 8'h00;
    else if (v.re) dout_m = mem_m[v.ra];
    if (v.we) mem_m[v.wa] = v.d;
    if (v.chk) check(nm, dout, v.exp);
  endtask

  vec_t ta[$];
  vec_t tb[$];

  initial begin
    dout_m = 'x;

    ta.push_back(mk(1,0,6'h00,8'h00,1,6'h00,1,8'h00));
    ta.push_back(mk(1,0,6'h00,8'h00,1,6'h00,1,8'h00));
    ta.push_back(mk(0,1,6'h00,8'hA5,0,6'h00,1,8'h00));
    ta.push_back(mk(0,0,6'h00,8'h00,1,6'h00,1,8'hA5));

    tb.push_back(mk(0,1,6'h10,8'h22,0,6'h00,0,8'h00));
    tb.push_back(mk(0,1,6'h05,8'h11,0,6'h00,0,8'h00));
    tb.push_back(mk(0,1,6'h21,8'h33,0,6'h00,0,8'h00));
    tb.push_back(mk(0,0,6'h00,8'h00,1,6'h10,1,8'h22));
    tb.push_back(mk(0,0,6'h00,8'h00,0,6'h11,1,8'h22));
    tb.push_back(mk(0,0,6'h00,8'h00,0,6'h11,1,8'h22));
    tb.push_back(mk(0,0,6'h00,8'h00,1,6'h11,1,8'h2D));
    tb.push_back(mk(0,1,6'h05,8'h99,1,6'h05,1,8'h11));
    tb.push_back(mk(0,0,6'h00,8'h00,1,6'h05,1,8'h99));
    tb.push_back(mk(0,1,6'h20,8'h7E,1,6'h21,1,8'h33));
    tb.push_back(mk(0,0,6'h00,8'h00,1,6'h20,1,8'h7E));
    tb.push_back(mk(1,1,6'h3F,8'hC3,1,6'h3F,1,8'h00));
    tb.push_back(mk(0,0,6'h00,8'h00,1,6'h3F,1,8'hC3));
    tb.push_back(mk(0,0,6'h00,8'h00,1,6'h3E,1,8'h02));
    tb.push_back(mk(0,0,6'h00,8'h00,1,6'h05,1,8'h99));
    tb.push_back(mk(0,0,6'h00,8'h00,1,6'h10,1,8'h22));

    foreach (ta[i]) run(ta[i], $sformatf("reset_vec%0d", i));

    for (int a = 0; a < 64; a++)
      run(mk(0,1,6'(a),8'(a) ^ 8'h3C,0,6'h00,0,8'h00), "fill");
    for (int a = 0; a < 64; a++)
      run(mk(0,0,6'h00,8'h00,1,6'(a),1,8'(a) ^ 8'h3C),
          $sformatf("readback_%02h", a));

    foreach (tb[i]) run(tb[i], $sformatf("corner_vec%0d", i));

    check("model_sync", dout, dout_m);

    for (int n = 0; n < 400; n++) begin
      vec_t v;
      v.rst = ($urandom_range(0, 19) == 0);
      v.we  = 1'($urandom);
      v.wa  = 6'($urandom);
      v.d   = 8'($urandom);
      v.re  = ($urandom_range(0, 3) != 0);
      v.ra  = ($urandom_range(0, 3) == 0) ? v.wa : 6'($urandom);
      v.chk = 1'b0;
      v.exp = 8'h00;
      run(v, "rand");
      check("rand", dout, dout_m);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
